// File: rtl/fpaddsub_pkg.sv
// Shared constants and types for the single-precision add/sub datapath.
// The InputExc bit indices are also used by the final exception/packing stage.
package fpaddsub_pkg;

  localparam int unsigned EW   = 8;
  localparam int unsigned MW   = 23;
  localparam int unsigned BIAS = 127;

  localparam logic [EW-1:0] EXP_ALL1     = 8'hFF;
  localparam logic [MW-1:0] QNAN_DEFAULT = 23'h400000;

  localparam int unsigned EXC_ANY    = 0;
  localparam int unsigned EXC_NAN_A  = 1;
  localparam int unsigned EXC_NAN_B  = 2;
  localparam int unsigned EXC_SNAN_A = 3;
  localparam int unsigned EXC_SNAN_B = 4;
  localparam int unsigned EXC_INF_A  = 5;
  localparam int unsigned EXC_INF_B  = 6;
  localparam int unsigned EXC_W      = 7;

  typedef struct packed {
    logic          nan;
    logic          snan;
    logic          inf;
    logic          hidden;
    logic [EW-1:0] effexp;
  } fp_class_t;

endpackage

// File: rtl/fpaddsub_classify.sv
// Combinational per-operand classifier: special-value flags, hidden bit and
// effective exponent (subnormals behave as exponent 1).
module fpaddsub_classify
  import fpaddsub_pkg::*;
(
  input  logic [EW-1:0] exp_i,
  input  logic [MW-1:0] man_i,
  output fp_class_t     cls_o
);

  logic exp_max;
  logic man_zero;

  always_comb begin
    exp_max      = (exp_i == EXP_ALL1);
    man_zero     = (man_i == '0);
    cls_o        = '0;
    cls_o.hidden = |exp_i;
    cls_o.nan    = exp_max & ~man_zero;
    cls_o.snan   = exp_max & ~man_zero & ~man_i[MW-1];
    cls_o.inf    = exp_max & man_zero;
    cls_o.effexp = cls_o.hidden ? exp_i : {{(EW-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/fpaddsub_operand_unpack.sv
// Two-stage front end of the FP add/sub pipe: S1 captures the operands, S2
// holds the classified, magnitude-ordered operand data for the adder.
module fpaddsub_operand_unpack
  import fpaddsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       A,
  input  logic [31:0]       B,
  input  logic [2:0]        Ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              Sa,
  output logic              Sb,
  output logic              MaxAB,
  output logic [EW-1:0]     Emax,
  output logic [EW-1:0]     ShiftAmt,
  output logic [MW:0]       Mmax,
  output logic [MW:0]       Mmin,
  output logic [EXC_W-1:0]  InputExc,
  output logic [MW-1:0]     MqNaN,
  output logic              Opr,
  output logic [2:0]        CtrlOut
);

  logic        s1_v_q, s2_v_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  ctrl_q;
  logic        s2_en;

  fp_class_t cls_a, cls_b;

  // S2 next-state
  logic             maxab_d;
  logic [EW-1:0]    emax_d, emin_d, shift_d;
  logic [MW:0]      mant_a, mant_b, mmax_d, mmin_d;
  logic [EXC_W-1:0] exc_d;
  logic [MW-1:0]    mqnan_d;

  // S2 registers
  logic             sa_q, sb_q, maxab_q, opr_q;
  logic [EW-1:0]    emax_q, shift_q;
  logic [MW:0]      mmax_q, mmin_q;
  logic [EXC_W-1:0] exc_q;
  logic [MW-1:0]    mqnan_q;
  logic [2:0]       ctrl_out_q;

  assign s2_en    = ~s2_v_q | out_ready;
  assign in_ready = ~s1_v_q | s2_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
    end else if (in_ready) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        a_q    <= A;
        b_q    <= B;
        ctrl_q <= Ctrl;
      end
    end
  end

  fpaddsub_classify u_cls_a (
    .exp_i (a_q[30:23]),
    .man_i (a_q[22:0]),
    .cls_o (cls_a)
  );

  fpaddsub_classify u_cls_b (
    .exp_i (b_q[30:23]),
    .man_i (b_q[22:0]),
    .cls_o (cls_b)
  );

  always_comb begin
    mant_a  = {cls_a.hidden, a_q[22:0]};
    mant_b  = {cls_b.hidden, b_q[22:0]};
    // Ties keep A as the larger operand.
    maxab_d = (b_q[30:0] > a_q[30:0]);
    emax_d  = maxab_d ? cls_b.effexp : cls_a.effexp;
    emin_d  = maxab_d ? cls_a.effexp : cls_b.effexp;
    shift_d = emax_d - emin_d;
    mmax_d  = maxab_d ? mant_b : mant_a;
    mmin_d  = maxab_d ? mant_a : mant_b;

    exc_d             = '0;
    exc_d[EXC_ANY]    = cls_a.nan | cls_a.inf | cls_b.nan | cls_b.inf;
    exc_d[EXC_NAN_A]  = cls_a.nan;
    exc_d[EXC_NAN_B]  = cls_b.nan;
    exc_d[EXC_SNAN_A] = cls_a.snan;
    exc_d[EXC_SNAN_B] = cls_b.snan;
    exc_d[EXC_INF_A]  = cls_a.inf;
    exc_d[EXC_INF_B]  = cls_b.inf;

    if (cls_a.nan) begin
      mqnan_d = {1'b1, a_q[21:0]};
    end else if (cls_b.nan) begin
      mqnan_d = {1'b1, b_q[21:0]};
    end else begin
      mqnan_d = QNAN_DEFAULT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q     <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      maxab_q    <= 1'b0;
      opr_q      <= 1'b0;
      emax_q     <= '0;
      shift_q    <= '0;
      mmax_q     <= '0;
      mmin_q     <= '0;
      exc_q      <= '0;
      mqnan_q    <= '0;
      ctrl_out_q <= '0;
    end else if (s2_en) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        sa_q       <= a_q[31];
        sb_q       <= b_q[31];
        maxab_q    <= maxab_d;
        opr_q      <= a_q[31] ^ b_q[31] ^ ctrl_q[0];
        emax_q     <= emax_d;
        shift_q    <= shift_d;
        mmax_q     <= mmax_d;
        mmin_q     <= mmin_d;
        exc_q      <= exc_d;
        mqnan_q    <= mqnan_d;
        ctrl_out_q <= ctrl_q;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign Sa        = sa_q;
  assign Sb        = sb_q;
  assign MaxAB     = maxab_q;
  assign Emax      = emax_q;
  assign ShiftAmt  = shift_q;
  assign Mmax      = mmax_q;
  assign Mmin      = mmin_q;
  assign InputExc  = exc_q;
  assign MqNaN     = mqnan_q;
  assign Opr       = opr_q;
  assign CtrlOut   = ctrl_out_q;

endmodule
